// File: rtl/guess_pkg.sv
// guess_pkg: shared types, constants and BCD helper for the guess scoreboard.
package guess_pkg;
  typedef enum logic [1:0] {PLAY, HOLD, OVER} score_state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [7:0] MAX_BCD = 8'h99;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v >= MAX_BCD) return MAX_BCD;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD incrementer with clear, saturating at 99.
module bcd_counter2
  import guess_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;
  always_comb q_d = clr ? 8'h00 : inc ? bcd_inc(q_q) : q_q;
  always_ff @(posedge clk)
    if (rst) q_q <= 8'h00;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/guess_scoreboard.sv
// guess_scoreboard: counts win/lose outcomes once per press and ends the match after ROUNDS outcomes.
module guess_scoreboard
  import guess_pkg::*;
#(
  parameter int unsigned ROUNDS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       win,
  input  logic       lose,
  output logic [7:0] win_bcd,
  output logic [7:0] lose_bcd,
  output logic [7:0] round_bcd,
  output logic [7:0] best_bcd,
  output logic       result_valid,
  output logic       last_win,
  output logic       game_over,
  output logic       player_won
);
  localparam logic [7:0] ROUNDS_BCD = {bcd_digit_t'(ROUNDS / 10), bcd_digit_t'(ROUNDS % 10)};
  score_state_t state_q;
  logic [7:0] streak, best_q, best_d;
  logic count_w, count_l, count_any, released;
  logic rv_q, lw_q, go_q, pw_q;
  assign count_w   = en && state_q == PLAY && win && !lose;
  assign count_l   = en && state_q == PLAY && lose;
  assign count_any = count_w || count_l;
  assign released  = en && state_q == HOLD && !win && !lose;
  always_comb best_d = (count_w && bcd_inc(streak) > best_q) ? bcd_inc(streak) : best_q;
  bcd_counter2 u_wins   (.clk(clk), .rst(rst), .clr(1'b0),    .inc(count_w),   .q(win_bcd));
  bcd_counter2 u_losses (.clk(clk), .rst(rst), .clr(1'b0),    .inc(count_l),   .q(lose_bcd));
  bcd_counter2 u_rounds (.clk(clk), .rst(rst), .clr(1'b0),    .inc(count_any), .q(round_bcd));
  bcd_counter2 u_streak (.clk(clk), .rst(rst), .clr(count_l), .inc(count_w),   .q(streak));
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= PLAY;
      best_q  <= 8'h00;
      rv_q    <= 1'b0;
      lw_q    <= 1'b0;
      go_q    <= 1'b0;
      pw_q    <= 1'b0;
    end else begin
      best_q <= best_d;
      rv_q   <= count_any;
      lw_q   <= count_any ? count_w : lw_q;
      case (state_q)
        PLAY: state_q <= count_any ? HOLD : PLAY;
        HOLD: if (released) begin
          state_q <= round_bcd == ROUNDS_BCD ? OVER : PLAY;
          go_q    <= round_bcd == ROUNDS_BCD;
          pw_q    <= round_bcd == ROUNDS_BCD && win_bcd > lose_bcd;
        end
        OVER: state_q <= OVER;
        default: state_q <= PLAY;
      endcase
    end
  assign best_bcd     = best_q;
  assign result_valid = rv_q;
  assign last_win     = lw_q;
  assign game_over    = go_q;
  assign player_won   = pw_q;
endmodule
